// File: rtl/board_reader_if.sv
// Bus between the board scanner, the board BRAM read port and game control.
// The slave side is the scanner; the master side is memory plus game logic.
interface board_reader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_enable;
    logic [2:0]        rd_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] red_count;
    logic [ADDR_W-1:0] blue_count;
    logic [ADDR_W-1:0] overlap_count;
    logic [ADDR_W-1:0] empty_count;
    logic              overlap_found;
    logic [ADDR_W-1:0] first_overlap_address;

    modport master (
        output start, rd_data,
        input  rd_address, rd_enable, busy, done,
               red_count, blue_count, overlap_count, empty_count,
               overlap_found, first_overlap_address
    );

    modport slave (
        input  start, rd_data,
        output rd_address, rd_enable, busy, done,
               red_count, blue_count, overlap_count, empty_count,
               overlap_found, first_overlap_address
    );
endinterface

// File: rtl/board_reader.sv
// Board read-back scanner: reads every cell of the board colour BRAM once and
// reports per-colour counts plus the lowest address holding an overlap.
module board_reader #(
    parameter int CELLS        = 256,
    parameter int ADDR_W       = 9,
    parameter int READ_LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    board_reader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0]       LAST_ADDR   = ADDR_W'(CELLS - 1);
    // Pattern of the valid pipe when only the final read is still outstanding.
    localparam logic [READ_LATENCY-1:0] OLDEST_ONLY = READ_LATENCY'(1'b1) << (READ_LATENCY - 1);

    localparam logic [2:0] CODE_RED     = 3'b100;
    localparam logic [2:0] CODE_BLUE    = 3'b001;
    localparam logic [2:0] CODE_OVERLAP = 3'b111;
    localparam logic [2:0] CODE_EMPTY   = 3'b000;

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    busy_s, rd_enable_s, done_s;
    logic [ADDR_W-1:0]       rd_address_s;
    logic                    busy_r, rd_enable_r, done_r;
    logic [ADDR_W-1:0]       rd_address_r;
    logic [READ_LATENCY-1:0] vld_r;
    logic [ADDR_W-1:0]       addr_pipe_r [READ_LATENCY];
    logic [ADDR_W-1:0]       red_r, blue_r, overlap_r, empty_r, first_r;
    logic                    found_r;
    logic                    start_accept_s;
    logic                    vld_out_s;

    assign start_accept_s = (state_r == IDLE) && bus.start;
    assign vld_out_s      = vld_r[READ_LATENCY-1];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = bus.start ? ISSUE : IDLE;
            ISSUE:   next_state_s = (rd_address_r == LAST_ADDR) ? DRAIN : ISSUE;
            DRAIN:   next_state_s = (vld_r == OLDEST_ONLY) ? DONE : DRAIN;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        busy_s       = 1'b0;
        rd_enable_s  = 1'b0;
        done_s       = 1'b0;
        rd_address_s = '0;
        case (next_state_s)
            IDLE: begin
                busy_s = 1'b0;
            end
            ISSUE: begin
                busy_s      = 1'b1;
                rd_enable_s = 1'b1;
                if (state_r == ISSUE) begin
                    rd_address_s = rd_address_r + ADDR_W'(1'b1);
                end else begin
                    rd_address_s = '0;
                end
            end
            DRAIN: begin
                busy_s = 1'b1;
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Registered handshake and read-port outputs; rd_address_r is the scan counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r       <= 1'b0;
            rd_enable_r  <= 1'b0;
            done_r       <= 1'b0;
            rd_address_r <= '0;
        end else begin
            busy_r       <= busy_s;
            rd_enable_r  <= rd_enable_s;
            done_r       <= done_s;
            rd_address_r <= rd_address_s;
        end
    end

    // Valid and address pipelines matching the BRAM read latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                addr_pipe_r[i] <= '0;
            end
        end else begin
            vld_r[0]       <= rd_enable_r;
            addr_pipe_r[0] <= rd_address_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_r[i]       <= vld_r[i-1];
                addr_pipe_r[i] <= addr_pipe_r[i-1];
            end
        end
    end

    // Classify returning data; results hold until the next accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            red_r     <= '0;
            blue_r    <= '0;
            overlap_r <= '0;
            empty_r   <= '0;
            found_r   <= 1'b0;
            first_r   <= '0;
        end else if (start_accept_s) begin
            red_r     <= '0;
            blue_r    <= '0;
            overlap_r <= '0;
            empty_r   <= '0;
            found_r   <= 1'b0;
            first_r   <= '0;
        end else if (vld_out_s) begin
            case (bus.rd_data)
                CODE_RED:   red_r   <= red_r + ADDR_W'(1'b1);
                CODE_BLUE:  blue_r  <= blue_r + ADDR_W'(1'b1);
                CODE_EMPTY: empty_r <= empty_r + ADDR_W'(1'b1);
                CODE_OVERLAP: begin
                    overlap_r <= overlap_r + ADDR_W'(1'b1);
                    if (!found_r) begin
                        found_r <= 1'b1;
                        first_r <= addr_pipe_r[READ_LATENCY-1];
                    end
                end
                default: begin
                    red_r <= red_r;
                end
            endcase
        end
    end

    assign bus.busy                  = busy_r;
    assign bus.done                  = done_r;
    assign bus.rd_enable             = rd_enable_r;
    assign bus.rd_address            = rd_address_r;
    assign bus.red_count             = red_r;
    assign bus.blue_count            = blue_r;
    assign bus.overlap_count         = overlap_r;
    assign bus.empty_count           = empty_r;
    assign bus.overlap_found         = found_r;
    assign bus.first_overlap_address = first_r;
endmodule

// File: tb/tb_board_reader.sv
// Directed bench for board_reader: latency-2 and latency-1 instances share one
// board memory image, each behind its own BRAM read pipeline.
module tb_board_reader;
    localparam int CELLS  = 256;
    localparam int ADDR_W = 9;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    board_reader_if #(.ADDR_W(ADDR_W)) bus0 ();
    board_reader_if #(.ADDR_W(ADDR_W)) bus1 ();

    board_reader #(.CELLS(CELLS), .ADDR_W(ADDR_W), .READ_LATENCY(2)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave)
    );
    board_reader #(.CELLS(CELLS), .ADDR_W(ADDR_W), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave)
    );

    logic [2:0] mem [CELLS];
    logic [2:0] q0_a, q0_b, q1_a;

    // BRAM models: two register stages for dut0, one for dut1.
    always @(posedge clock) begin
        q0_a <= mem[bus0.rd_address[7:0]];
        q0_b <= q0_a;
        q1_a <= mem[bus1.rd_address[7:0]];
    end
    assign bus0.rd_data = q0_b;
    assign bus1.rd_data = q1_a;

    int sel = 0;
    logic              s_busy, s_done, s_found;
    logic [ADDR_W-1:0] s_red, s_blue, s_ovl, s_empty, s_first;
    assign s_busy  = (sel != 0) ? bus1.busy : bus0.busy;
    assign s_done  = (sel != 0) ? bus1.done : bus0.done;
    assign s_found = (sel != 0) ? bus1.overlap_found : bus0.overlap_found;
    assign s_red   = (sel != 0) ? bus1.red_count : bus0.red_count;
    assign s_blue  = (sel != 0) ? bus1.blue_count : bus0.blue_count;
    assign s_ovl   = (sel != 0) ? bus1.overlap_count : bus0.overlap_count;
    assign s_empty = (sel != 0) ? bus1.empty_count : bus0.empty_count;
    assign s_first = (sel != 0) ? bus1.first_overlap_address : bus0.first_overlap_address;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_start(input int s, input logic v);
        if (s != 0) bus1.start = v;
        else        bus0.start = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < CELLS; i++) mem[i] = 3'b000;
    endtask

    task automatic run_scan(input int s, input bit hold, input int exp_done, input string name);
        int done_at, pulses, busy_gaps, extra_busy;
        logic busy_at_done;
        done_at = 0; pulses = 0; busy_gaps = 0; extra_busy = 0; busy_at_done = 1'b1;
        sel = s;
        @(posedge clock); #1;
        drive_start(s, 1'b1);
        @(posedge clock);
        #1;
        if (!hold) drive_start(s, 1'b0);
        for (int n = 1; n <= 400 && done_at == 0; n++) begin
            @(negedge clock);
            if (s_done) begin
                done_at = n;
                pulses++;
                busy_at_done = s_busy;
            end else if (!s_busy) begin
                busy_gaps++;
            end
        end
        @(posedge clock); #1;
        drive_start(s, 1'b0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (s_done) pulses++;
            if (s_busy) extra_busy++;
        end
        check({name, "_done_cycle"}, done_at, exp_done);
        check({name, "_busy_gaps"}, busy_gaps, 0);
        check({name, "_busy_at_done"}, {31'd0, busy_at_done}, 0);
        check({name, "_done_pulses"}, pulses, 1);
        check({name, "_busy_after"}, extra_busy, 0);
    endtask

    task automatic check_counts(input string name, input int red, input int blue, input int ovl,
                                input int empty, input int found, input int first);
        check({name, "_red"}, {23'd0, s_red}, red);
        check({name, "_blue"}, {23'd0, s_blue}, blue);
        check({name, "_overlap"}, {23'd0, s_ovl}, ovl);
        check({name, "_empty"}, {23'd0, s_empty}, empty);
        check({name, "_found"}, {31'd0, s_found}, found);
        check({name, "_first"}, {23'd0, s_first}, first);
    endtask

    initial begin
        int done_seen;
        clear_mem();
        reset = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, bus0.busy}, 0);
        check("rst_done", {31'd0, bus0.done}, 0);
        check("rst_rden", {31'd0, bus0.rd_enable}, 0);
        check("rst_addr", {23'd0, bus0.rd_address}, 0);
        check("rst_empty", {23'd0, bus0.empty_count}, 0);
        check("rst_found", {31'd0, bus0.overlap_found}, 0);
        reset = 1'b0;

        // All-empty board.
        run_scan(0, 1'b0, 259, "zero");
        check_counts("zero", 0, 0, 0, 256, 0, 0);

        // One red and one blue cell.
        mem[17] = 3'b100;
        mem[200] = 3'b001;
        run_scan(0, 1'b0, 259, "rb");
        check_counts("rb", 1, 1, 0, 254, 0, 0);

        // Overlaps at both ends plus an unclassified code.
        clear_mem();
        mem[0] = 3'b111;
        mem[255] = 3'b111;
        mem[5] = 3'b010;
        run_scan(0, 1'b0, 259, "ends");
        check_counts("ends", 0, 0, 2, 253, 1, 0);

        // start held through the whole scan and the DONE cycle.
        clear_mem();
        mem[37] = 3'b111;
        mem[100] = 3'b111;
        mem[101] = 3'b100;
        run_scan(0, 1'b1, 259, "hold");
        check_counts("hold", 1, 0, 2, 253, 1, 37);

        // Reset in the middle of a scan.
        clear_mem();
        sel = 0;
        @(posedge clock); #1;
        drive_start(0, 1'b1);
        @(posedge clock); #1;
        drive_start(0, 1'b0);
        repeat (99) @(posedge clock);
        #2;
        check("pre_rst_busy", {31'd0, bus0.busy}, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, bus0.busy}, 0);
        check("mid_rst_rden", {31'd0, bus0.rd_enable}, 0);
        check("mid_rst_empty", {23'd0, bus0.empty_count}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (bus0.done) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 0);
        mem[9] = 3'b001;
        run_scan(0, 1'b0, 259, "restart");
        check_counts("restart", 0, 1, 0, 255, 0, 0);

        // Latency-1 instance, red cell at the last address.
        clear_mem();
        mem[255] = 3'b100;
        run_scan(1, 1'b0, 258, "lat1");
        check_counts("lat1", 1, 0, 0, 255, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
